lwe_body_acc: RTL and testbench

Sequential LWE body accumulator for the CGGI key-generation datapath. Streams `n` mask coefficients `a_i` with binary secret-key bits `s_i` and computes `b = (sum_i a_i*s_i + e) mod Q`. It sits directly downstream of the mask/key sampler and drives the modular adder on every accepted beat. It emits one body word per ciphertext.

---
 rtl/lwe_acc_pkg.sv | 20 ++
 rtl/mod_add_q.sv | 29 ++
 rtl/lwe_body_acc.sv | 126 ++++++++++++
 tb/tb_lwe_body_acc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lwe_acc_pkg.sv
// Shared types and defaults for the LWE body accumulator.
// Holds the FSM state encoding and the modular-adder width helper.
package lwe_acc_pkg;

    parameter int unsigned DEFAULT_DATA_WIDTH = 32;
    parameter int unsigned DEFAULT_N_WIDTH    = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StErr  = 2'd2,
        StOut  = 2'd3
    } lwe_acc_state_e;

    // One guard bit keeps the unreduced sum of two residues from overflowing.
    function automatic int unsigned sum_width(input int unsigned data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/mod_add_q.sv
// Combinational two-operand modular adder: y = (a + b) mod q for a, b in [0, q).
// A sum equal to q reduces to 0.
module mod_add_q
    import lwe_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] y
);

    localparam int unsigned SumW = sum_width(DATA_WIDTH);

    logic [SumW-1:0] sum_full;
    logic [SumW-1:0] q_ext;

    always_comb begin
        q_ext    = {1'b0, q};
        sum_full = {1'b0, a} + {1'b0, b};
        if (sum_full >= q_ext) begin
            y = DATA_WIDTH'(sum_full - q_ext);
        end else begin
            y = DATA_WIDTH'(sum_full);
        end
    end

endmodule

// File: rtl/lwe_body_acc.sv
// Sequential LWE body accumulator: b = (sum a_i*s_i + e) mod Q over n streamed beats.
// Define LWE_ACC_ERR_EN to add the error beat and the e_in port.
module lwe_body_acc
    import lwe_acc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned n_WIDTH    = DEFAULT_N_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [n_WIDTH-1:0]    n,
    input  logic [DATA_WIDTH-1:0] Q,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic                  s_in,
`ifdef LWE_ACC_ERR_EN
    input  logic [DATA_WIDTH-1:0] e_in,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ready,
    output logic                  done
);

`ifdef LWE_ACC_ERR_EN
    localparam lwe_acc_state_e AccExit = StErr;
`else
    localparam lwe_acc_state_e AccExit = StOut;
`endif

    lwe_acc_state_e state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic [n_WIDTH-1:0]    cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] add_b;
    logic [DATA_WIDTH-1:0] add_sum;

    // Single adder shared by the coefficient and error beats.
    mod_add_q #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mod_add (
        .a(acc_q),
        .b(add_b),
        .q(q_q),
        .y(add_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        add_b     = a_in;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        ready     = 1'b0;
        done      = 1'b0;

        case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    q_d   = Q;
                    acc_d = '0;
                    cnt_d = n;
                    state_d = (n == '0) ? AccExit : StAcc;
                end
            end
            StAcc: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (s_in) begin
                        acc_d = add_sum;
                    end
                    cnt_d = cnt_q - 1'b1;
                    // <= keeps the FSM terminating even if cnt_q were ever 0 here.
                    if (cnt_q <= n_WIDTH'(1)) begin
                        state_d = AccExit;
                    end
                end
            end
            StErr: begin
`ifdef LWE_ACC_ERR_EN
                in_ready = 1'b1;
                // Fold a negative two's-complement error into [0, Q).
                add_b = e_in[DATA_WIDTH-1] ? (e_in + q_q) : e_in;
                if (in_valid) begin
                    acc_d   = add_sum;
                    state_d = StOut;
                end
`else
                state_d = StOut;
`endif
            end
            StOut: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign out = acc_q;

endmodule

// File: tb/tb_lwe_body_acc.sv
// Scoreboard bench for lwe_body_acc; expected bodies are queued at start and
// checked by a monitor on each output handshake. Works with or without LWE_ACC_ERR_EN.
module tb_lwe_body_acc;

`ifdef LWE_ACC_ERR_EN
    localparam bit HasErr = 1'b1;
`else
    localparam bit HasErr = 1'b0;
`endif

    typedef logic [31:0] vec_t [8];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  n = '0;
    logic [31:0] Q = '0;
    logic [31:0] a_in = '0;
    logic        s_in = 1'b0;
    logic [31:0] e_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        ready;
    logic        done;

    lwe_body_acc #(
        .DATA_WIDTH(32),
        .n_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .n(n),
        .Q(Q),
        .a_in(a_in),
        .s_in(s_in),
`ifdef LWE_ACC_ERR_EN
        .e_in(e_in),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out(out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ready(ready),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int start_cyc = 0;
    int exp_lat = 0;
    bit lat_check_en = 1'b0;
    bit seen_valid = 1'b0;
    vec_t av;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: scoreboard pop, done pulse, output stability, latency.
    initial begin
        logic        hold_prev;
        logic [31:0] out_prev;
        logic [31:0] expv;
        hold_prev = 1'b0;
        out_prev  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (hold_prev && out_valid) chk("out_stable", out, out_prev);
                if (out_valid && !seen_valid) begin
                    seen_valid = 1'b1;
                    if (lat_check_en) chk("latency", 32'(cyc - start_cyc + 1), 32'(exp_lat));
                end
                if (out_valid || done) chk("done_pulse", {31'b0, done}, {31'b0, out_valid && out_ready});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        expv = exp_q.pop_front();
                        chk("body", out, expv);
                    end
                end
                hold_prev = out_valid && !out_ready;
                out_prev  = out;
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap: insert in_valid gaps plus ignored start pulses; stall: hold out_ready low 5 cycles.
    task automatic run_op(input int nn, input logic [31:0] qq, input logic [7:0] sv,
                          input logic [31:0] ev, input logic [31:0] expv,
                          input bit gap, input bit stall);
        bit got;
        exp_q.push_back(expv);
        tick();
        start = 1'b1;
        n = 8'(nn);
        Q = qq;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        seen_valid = 1'b0;
        lat_check_en = !gap && !stall;
        exp_lat = nn + (HasErr ? 2 : 1);
        if (stall) out_ready = 1'b0;
        for (int i = 0; i < nn; i++) begin
            if (gap && (i % 2 == 0)) begin
                in_valid = 1'b0;
                a_in = 32'h0BAD_0BAD;
                s_in = 1'b1;
                start = 1'b1;
                n = 8'd1;
                repeat ($urandom_range(1, 3)) tick();
                start = 1'b0;
                n = 8'(nn);
            end
            in_valid = 1'b1;
            a_in = av[i];
            s_in = sv[i];
            tick();
        end
        if (HasErr) begin
            in_valid = 1'b1;
            e_in = ev;
            tick();
        end
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            if (out_valid) got = 1'b1;
            else tick();
        end
        if (!got) chk("out_valid_timeout", 32'd0, 32'd1);
        if (stall) begin
            start = 1'b1;
            n = 8'd2;
            tick();
            start = 1'b0;
            repeat (4) tick();
            out_ready = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            tick();
            if (ready) got = 1'b1;
        end
        if (!got) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #3;
        @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out", out, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b1;

        av = '{32'd5, 32'd16, 32'd9, 32'd3, 0, 0, 0, 0};
        run_op(4, 32'd17, 8'b0000_1011, -32'sd2, HasErr ? 32'd5 : 32'd7, 1'b0, 1'b0);

        av = '{32'd16, 32'd16, 32'd16, 0, 0, 0, 0, 0};
        run_op(3, 32'd17, 8'b0000_0111, 32'd0, 32'd14, 1'b0, 1'b0);

        av = '{32'd16, 0, 0, 0, 0, 0, 0, 0};
        run_op(1, 32'd17, 8'b0000_0001, 32'd1, HasErr ? 32'd0 : 32'd16, 1'b0, 1'b0);

        av = '{32'd9, 32'd8, 0, 0, 0, 0, 0, 0};
        run_op(2, 32'd17, 8'b0000_0011, 32'd0, 32'd0, 1'b0, 1'b0);

        av = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_op(0, 32'd17, 8'b0, 32'd3, HasErr ? 32'd3 : 32'd0, 1'b0, 1'b0);

        av = '{32'h7FFF_FFFE, 32'h7FFF_FFFE, 0, 0, 0, 0, 0, 0};
        run_op(2, 32'h7FFF_FFFF, 8'b0000_0011, 32'd0, 32'h7FFF_FFFD, 1'b0, 1'b0);

        av = '{32'd10, 32'd3, 0, 0, 0, 0, 0, 0};
        run_op(2, 32'd17, 8'b0000_0010, -32'sd5, HasErr ? 32'd15 : 32'd3, 1'b0, 1'b0);

        // Backpressure: input gaps, ignored start pulses, output stall.
        av = '{32'd5, 32'd16, 32'd9, 32'd3, 0, 0, 0, 0};
        run_op(4, 32'd17, 8'b0000_1011, -32'sd2, HasErr ? 32'd5 : 32'd7, 1'b1, 1'b1);

        // Reset during the second ACC beat.
        tick();
        start = 1'b1;
        n = 8'd3;
        Q = 32'd17;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        a_in = 32'd16;
        s_in = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_out", out, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;

        av = '{32'd16, 32'd16, 32'd16, 0, 0, 0, 0, 0};
        run_op(3, 32'd17, 8'b0000_0111, 32'd0, 32'd14, 1'b0, 1'b0);

        repeat (3) tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
